serial_adder: RTL and testbench

- Bit-serial unsigned adder: accepts two WIDTH-bit operands on a start strobe and adds them one bit per clock, LSB first.
- The datapath is a single `one_bit_full_adder` instance (ports a, b, ci, s, co) with a registered carry.
- Sits directly around the full-adder stage: it feeds the cell one operand bit pair plus the carry each cycle and consumes its s/co outputs.
- Presents the assembled sum and carry-out through a start/busy/done handshake.

---
 rtl/serial_adder.sv | 151 +++++++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial unsigned adder, LSB first, one bit per clock.
//
// A single one_bit_full_adder cell does all the arithmetic. The operands are
// loaded into shift registers on an accepted start. Each SHIFT cycle feeds the
// cell one bit pair plus the registered carry. The sum bits are shifted in at
// the MSB of a result shift register.
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   When defined, adds the ovf port (two's-complement overflow of the add).
//
// Ports:
//   clk    in   rising-edge clock, the only clock
//   rst    in   synchronous active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   a_in   in   [WIDTH-1:0] operand A, captured on an accepted start
//   b_in   in   [WIDTH-1:0] operand B, captured on an accepted start
//   busy   out  high while bits are being added (exactly WIDTH cycles)
//   done   out  one-cycle pulse: sum/cout newly valid
//   sum    out  [WIDTH-1:0] result, held until the next completion
//   cout   out  carry out of bit WIDTH-1, held like sum
//   ovf    out  signed overflow (only with SERIAL_ADDER_OVF_EN)

module one_bit_full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_reg;
   logic [WIDTH-1:0] sa_reg;
   logic [WIDTH-1:0] sb_reg;
   logic [WIDTH-1:0] ss_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;

   logic             fa_s;
   logic             fa_co;
   logic [WIDTH-1:0] ss_next;

   one_bit_full_adder u_fa (
      .a  (sa_reg[0]),
      .b  (sb_reg[0]),
      .ci (carry_reg),
      .s  (fa_s),
      .co (fa_co)
   );

   // The result register as it will look after this cycle's sum bit enters.
   // It is also the value loaded into sum on the last SHIFT cycle.
   assign ss_next = {fa_s, ss_reg[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVF_EN
   localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);
   // Carry into the MSB. It is captured as the carry-out of bit WIDTH-2,
   // which is the same value carry_reg holds while cnt == WIDTH-1.
   logic cmsb_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sa_reg    <= '0;
         sb_reg    <= '0;
         ss_reg    <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         cmsb_reg  <= 1'b0;
         ovf       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            // DONE accepts a new start exactly like IDLE. This allows
            // back-to-back operation with no bubble cycle.
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa_reg    <= a_in;
                  sb_reg    <= b_in;
                  carry_reg <= 1'b0;
                  cnt_reg   <= '0;
                  busy      <= 1'b1;
                  state_reg <= SHIFT;
               end else begin
                  state_reg <= IDLE;
               end
            end

            SHIFT: begin
               carry_reg <= fa_co;
               ss_reg    <= ss_next;
               sa_reg    <= sa_reg >> 1;
               sb_reg    <= sb_reg >> 1;
               cnt_reg   <= cnt_reg + 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
               if (cnt_reg == CNT_PENULT) begin
                  cmsb_reg <= fa_co;
               end
`endif
               if (cnt_reg == CNT_LAST) begin
                  sum       <= ss_next;
                  cout      <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf       <= cmsb_reg ^ fa_co;
`endif
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_reg <= DONE;
               end
            end

            default: begin
               busy      <= 1'b0;
               done      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- directed and randomized checks of serial_adder (WIDTH=8).
// The reference model is plain integer addition of the operands.
// Define SERIAL_ADDER_OVF_EN here as well as in the RTL to check ovf.

module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int vectors   = 0;
   int miscompares = 0;

   // Model state: the last completed result, which the outputs must hold.
   logic [W-1:0] exp_sum;
   logic         exp_cout;
   logic         exp_ovf;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_held(input string tag);
      check({tag, "_sum"}, {1'b0, sum}, {1'b0, exp_sum});
      check({tag, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, exp_ovf});
`endif
   endtask

   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] r;
      r = {1'b0, a} + {1'b0, b};
      exp_sum  = r[W-1:0];
      exp_cout = r[W];
      // Same-sign operands and a result of the other sign is a signed overflow.
      exp_ovf  = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
   endtask

   // Run the busy phase of an op that has just been accepted. Operands and
   // stray start pulses are scrambled to show they are ignored. The task
   // returns just after the completion edge.
   task automatic run_busy(input string tag, input bit hold_start);
      for (int j = 0; j < W; j++) begin
         check({tag, "_busy"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
         check({tag, "_nodone"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b0});
         check_held({tag, "_hold"});
         a_in = W'($urandom);
         b_in = W'($urandom);
         if (!hold_start) start = 1'($urandom);
         step();
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
      check({tag, "_busy0"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b0});
      check_held(tag);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      step();
      start = 1'b0;
      run_busy(tag, 1'b0);
      start = 1'b0;
      model(a, b);
      check_done(tag);
      step();
      check({tag, "_pulse"}, {{W{1'b0}}, done}, {{W{1'b0}}, 1'b0});
      check({tag, "_idle"}, {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b0});
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Idle after reset.
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_busy", {{W{1'b0}}, busy}, '0);
         check("rst_done", {{W{1'b0}}, done}, '0);
         check_held("rst");
      end

      run_op("op5a3c", 8'h5A, 8'h3C);
      run_op("opff01", 8'hFF, 8'h01);
      run_op("op7f01", 8'h7F, 8'h01);

      // start held high: back-to-back operations with no bubble.
      start = 1'b1; a_in = 8'h10; b_in = 8'h20;
      step();
      a_in = 8'h01; b_in = 8'h02;
      begin
         // Operands for the second accept must be stable at the DONE edge,
         // so only the first busy phase is checked without scrambling.
         for (int j = 0; j < W; j++) begin
            check("b2b1_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
            check_held("b2b1_hold");
            step();
         end
      end
      model(8'h10, 8'h20);
      check_done("b2b1");
      step();
      check("b2b2_nodone", {{W{1'b0}}, done}, '0);
      check("b2b2_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
      for (int j = 1; j < W; j++) begin
         step();
         check("b2b2_busy", {{W{1'b0}}, busy}, {{W{1'b0}}, 1'b1});
      end
      step();
      model(8'h01, 8'h02);
      check_done("b2b2");
      start = 1'b0;
      step();
      check("b2b_end", {{W{1'b0}}, busy}, '0);

      // Reset during the 4th SHIFT cycle aborts with no done pulse.
      start = 1'b1; a_in = 8'hAA; b_in = 8'h55;
      step();
      start = 1'b0;
      for (int j = 0; j < 3; j++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
      check("abort_busy", {{W{1'b0}}, busy}, '0);
      check("abort_done", {{W{1'b0}}, done}, '0);
      check_held("abort");
      for (int j = 0; j < W + 2; j++) begin
         step();
         check("abort_nodone", {{W{1'b0}}, done}, '0);
         check("abort_nobusy", {{W{1'b0}}, busy}, '0);
      end
      run_op("opaa55", 8'hAA, 8'h55);

      // Randomized operations with random idle gaps.
      for (int n = 0; n < 24; n++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         run_op("rand", ra, rb);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
